// File: rtl/display_pkg.sv
// Shared constants and helpers for the display compositor slice.
package display_pkg;
  localparam int   FADEW      = 5;
  localparam int   FADE_FULL  = 16;
  localparam logic EN_RST     = 1'b1;
  localparam logic KEY_EN_RST = 1'b1;

  // Input-to-display latency of the compositor for a given CLUT read latency.
  function automatic int comp_latency(input int clut_lat);
    return clut_lat + 3;
  endfunction
endpackage

// File: rtl/display_compositor_if.sv
// CLUT read port plus aligned display output bundle.
interface display_compositor_if #(
  parameter int CORDW      = 16,
  parameter int BPC        = 5,
  parameter int CLUT_ADDRW = 8
);
  logic [CLUT_ADDRW-1:0]   clut_addr;
  logic [3*BPC-1:0]        clut_dout;
  logic signed [CORDW-1:0] disp_x, disp_y;
  logic                    disp_hsync, disp_vsync, disp_de, disp_frame;
  logic [BPC-1:0]          disp_r, disp_g, disp_b;

  modport master (
    output clut_addr, disp_x, disp_y, disp_hsync, disp_vsync, disp_de, disp_frame,
           disp_r, disp_g, disp_b,
    input  clut_dout
  );
  modport slave (
    input  clut_addr, disp_x, disp_y, disp_hsync, disp_vsync, disp_de, disp_frame,
           disp_r, disp_g, disp_b,
    output clut_dout
  );
endinterface

// File: rtl/display_compositor_pipe_delay.sv
// Reset-clearing shift register used to keep side-band signals aligned with the colour path.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/display_compositor.sv
// Layer priority select -> CLUT lookup -> background/fade mix -> aligned display outputs.
module display_compositor
  import display_pkg::*;
#(
  parameter int LAYERS     = 2,
  parameter int CIDXW      = 4,
  parameter int CLUT_ADDRW = 8,
  parameter int BPC        = 5,
  parameter int CORDW      = 16,
  parameter int CLUT_LAT   = 2,
  parameter logic [3*BPC-1:0] BG_COLR = 'h0886
) (
  input  logic                        clk_pix,
  input  logic                        rst_pix,
  input  logic signed [CORDW-1:0]     dx,
  input  logic signed [CORDW-1:0]     dy,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        de,
  input  logic                        frame_start,
  input  logic [LAYERS-1:0]           layer_paint,
  input  logic [LAYERS*CIDXW-1:0]     layer_pix,
  input  logic                        cfg_stb,
  input  logic [LAYERS-1:0]           cfg_en,
  input  logic [LAYERS-1:0]           cfg_key_en,
  input  logic [LAYERS*CLUT_ADDRW-1:0] cfg_pal_base,
  input  logic [3*BPC-1:0]            cfg_bg,
  input  logic [FADEW-1:0]            cfg_fade,
  output logic                        cfg_pending,
  display_compositor_if.master        dout
);
  localparam int LAT = comp_latency(CLUT_LAT);
  localparam int TW  = 2*CORDW + 4;
  localparam int PW  = BPC + 5;

  typedef struct packed {
    logic [LAYERS-1:0]            en;
    logic [LAYERS-1:0]            key_en;
    logic [LAYERS*CLUT_ADDRW-1:0] pal_base;
    logic [3*BPC-1:0]             bg;
    logic [FADEW-1:0]             fade;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    en:       {LAYERS{EN_RST}},
    key_en:   {LAYERS{KEY_EN_RST}},
    pal_base: '0,
    bg:       BG_COLR,
    fade:     FADEW'(FADE_FULL)
  };

  cfg_t act, shd, act_eff, cfg_in;
  logic apply;

  assign cfg_in  = '{en: cfg_en, key_en: cfg_key_en, pal_base: cfg_pal_base,
                     bg: cfg_bg, fade: cfg_fade};
  assign apply   = frame_start & cfg_pending;
  // The pixel carrying frame_start already sees the newly applied set.
  assign act_eff = apply ? shd : act;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      act         <= CFG_RST;
      shd         <= CFG_RST;
      cfg_pending <= 1'b0;
    end else begin
      if (apply) act <= shd;
      if (cfg_stb) begin
        shd         <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Stage 1: eligibility and lowest-index priority select
  logic [LAYERS-1:0]     elig;
  logic [CLUT_ADDRW-1:0] sel_addr;
  logic                  hit_s1;

  for (genvar i = 0; i < LAYERS; i++) begin : g_elig
    assign elig[i] = act_eff.en[i] & layer_paint[i] &
                     ~(act_eff.key_en[i] & (layer_pix[i*CIDXW +: CIDXW] == '0));
  end

  always_comb begin
    sel_addr = '0;
    for (int i = LAYERS-1; i >= 0; i--) begin
      if (elig[i])
        sel_addr = act_eff.pal_base[i*CLUT_ADDRW +: CLUT_ADDRW] +
                   CLUT_ADDRW'(layer_pix[i*CIDXW +: CIDXW]);
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      dout.clut_addr <= '0;
      hit_s1         <= 1'b0;
    end else begin
      hit_s1 <= |elig;
      if (|elig) dout.clut_addr <= sel_addr;
    end
  end

  // Delay lines matched to the CLUT read
  logic          hit_d;
  logic [TW-1:0] tim_d, tim_q;
  assign tim_d = {dx, dy, hsync, vsync, de, frame_start};

  pipe_delay #(.WIDTH(1), .DEPTH(LAT-3)) u_hit_dly (
    .clk(clk_pix), .rst(rst_pix), .d(hit_s1), .q(hit_d)
  );
  pipe_delay #(.WIDTH(TW), .DEPTH(LAT-1)) u_tim_dly (
    .clk(clk_pix), .rst(rst_pix), .d(tim_d), .q(tim_q)
  );

  // Mix stage: background substitution and fade scaling
  logic [3*BPC-1:0] colr, mixed, mix_q;
  logic [FADEW-1:0] f;

  assign colr = hit_d ? dout.clut_dout : act.bg;
  assign f    = (act.fade > FADEW'(FADE_FULL)) ? FADEW'(FADE_FULL) : act.fade;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [PW-1:0] prod;
    assign prod = PW'(colr[c*BPC +: BPC]) * PW'(f);
    assign mixed[c*BPC +: BPC] = BPC'(prod >> 4);
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) mix_q <= '0;
    else         mix_q <= mixed;
  end

  // Output stage
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      dout.disp_x     <= '0;
      dout.disp_y     <= '0;
      dout.disp_hsync <= 1'b0;
      dout.disp_vsync <= 1'b0;
      dout.disp_de    <= 1'b0;
      dout.disp_frame <= 1'b0;
      dout.disp_r     <= '0;
      dout.disp_g     <= '0;
      dout.disp_b     <= '0;
    end else begin
      dout.disp_x     <= tim_q[TW-1 -: CORDW];
      dout.disp_y     <= tim_q[4 +: CORDW];
      dout.disp_hsync <= tim_q[3];
      dout.disp_vsync <= tim_q[2];
      dout.disp_de    <= tim_q[1];
      dout.disp_frame <= tim_q[0];
      dout.disp_r     <= tim_q[1] ? mix_q[2*BPC +: BPC] : '0;
      dout.disp_g     <= tim_q[1] ? mix_q[BPC +: BPC]   : '0;
      dout.disp_b     <= tim_q[1] ? mix_q[0 +: BPC]     : '0;
    end
  end
endmodule

// File: tb/tb_display_compositor.sv
// Directed + randomized bench for display_compositor against a per-pixel reference model.
module tb_display_compositor;
  localparam int LAT = 5;  // CLUT_LAT=2 -> 5 cycles input to display

  logic        clk_pix = 1'b0;
  logic        rst_pix = 1'b1;
  logic [15:0] dx = '0, dy = '0;
  logic        hsync = 0, vsync = 0, de = 0, frame_start = 0;
  logic [1:0]  layer_paint = '0;
  logic [7:0]  layer_pix = '0;
  logic        cfg_stb = 0;
  logic [1:0]  cfg_en = 2'b11, cfg_key_en = 2'b11;
  logic [15:0] cfg_pal_base = '0;
  logic [14:0] cfg_bg = 15'h0886;
  logic [4:0]  cfg_fade = 5'd16;
  logic        cfg_pending;

  display_compositor_if #(.CORDW(16), .BPC(5), .CLUT_ADDRW(8)) dif ();

  display_compositor #(
    .LAYERS(2), .CIDXW(4), .CLUT_ADDRW(8), .BPC(5), .CORDW(16), .CLUT_LAT(2),
    .BG_COLR(15'h0886)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .dx(dx), .dy(dy), .hsync(hsync),
    .vsync(vsync), .de(de), .frame_start(frame_start), .layer_paint(layer_paint),
    .layer_pix(layer_pix), .cfg_stb(cfg_stb), .cfg_en(cfg_en), .cfg_key_en(cfg_key_en),
    .cfg_pal_base(cfg_pal_base), .cfg_bg(cfg_bg), .cfg_fade(cfg_fade),
    .cfg_pending(cfg_pending), .dout(dif.master)
  );

  always #5 clk_pix = ~clk_pix;

  // CLUT: static contents, two-cycle read
  logic [14:0] mem [256];
  logic [14:0] c1, c2;
  always @(posedge clk_pix) begin
    c1 <= mem[dif.clut_addr];
    c2 <= c1;
  end
  assign dif.clut_dout = c2;

  typedef struct packed {
    logic [15:0] x, y;
    logic        hs, vs, de, fr;
    logic [4:0]  r, g, b;
  } rec_t;

  int checks = 0, errors = 0;

  // Reference model state
  logic [1:0]  a_en, a_key, s_en, s_key;
  int          a_base [2], s_base [2];
  logic [14:0] a_bg, s_bg;
  int          a_fade, s_fade;
  bit          m_pend;
  int          m_addr;
  rec_t        q [$];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic rec_t obs();
    rec_t r;
    r.x = dif.disp_x; r.y = dif.disp_y;
    r.hs = dif.disp_hsync; r.vs = dif.disp_vsync; r.de = dif.disp_de; r.fr = dif.disp_frame;
    r.r = dif.disp_r; r.g = dif.disp_g; r.b = dif.disp_b;
    return r;
  endfunction

  task automatic model_reset();
    a_en = 2'b11; a_key = 2'b11; a_base[0] = 0; a_base[1] = 0; a_bg = 15'h0886; a_fade = 16;
    s_en = 2'b11; s_key = 2'b11; s_base[0] = 0; s_base[1] = 0; s_bg = 15'h0886; s_fade = 16;
    m_pend = 0; m_addr = 0;
    q.delete();
    repeat (LAT-1) q.push_back('0);
  endtask

  function automatic int scale(input int ch, input int fade);
    int f;
    f = (fade > 16) ? 16 : fade;
    return (ch * f) / 16;
  endfunction

  // One pixel: model it, clock it, compare everything
  task automatic tick();
    rec_t e;
    bit apply, hit;
    int p;
    logic [14:0] c;
    apply = frame_start && m_pend;
    if (apply) begin
      a_en = s_en; a_key = s_key; a_base = s_base; a_bg = s_bg; a_fade = s_fade;
    end
    hit = 0;
    for (int i = 0; i < 2; i++) begin
      p = int'(layer_pix[i*4 +: 4]);
      if (!hit && a_en[i] && layer_paint[i] && !(a_key[i] && p == 0)) begin
        hit = 1;
        m_addr = (a_base[i] + p) % 256;
      end
    end
    c = hit ? mem[m_addr] : a_bg;
    e = '0;
    e.x = dx; e.y = dy; e.hs = hsync; e.vs = vsync; e.de = de; e.fr = frame_start;
    if (de) begin
      e.r = 5'(scale(int'(c[14:10]), a_fade));
      e.g = 5'(scale(int'(c[9:5]), a_fade));
      e.b = 5'(scale(int'(c[4:0]), a_fade));
    end
    q.push_back(e);
    if (cfg_stb) begin
      s_en = cfg_en; s_key = cfg_key_en;
      s_base[0] = int'(cfg_pal_base[7:0]); s_base[1] = int'(cfg_pal_base[15:8]);
      s_bg = cfg_bg; s_fade = int'(cfg_fade);
      m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    @(posedge clk_pix); #1;
    chk("disp", 64'(obs()), 64'(q.pop_front()));
    chk("clut_addr", 64'(dif.clut_addr), 64'(m_addr));
    chk("cfg_pending", 64'(cfg_pending), 64'(m_pend));
  endtask

  task automatic idle(input int n);
    de = 0; layer_paint = 0; cfg_stb = 0; frame_start = 0;
    repeat (n) tick();
  endtask

  task automatic set_cfg(input logic [1:0] en, input logic [1:0] key, input int b0,
                         input int b1, input logic [14:0] bg, input int fade);
    cfg_en = en; cfg_key_en = key;
    cfg_pal_base = {8'(b1), 8'(b0)};
    cfg_bg = bg; cfg_fade = 5'(fade);
  endtask

  // Program a set and apply it at a clean frame boundary
  task automatic program_frame(input logic [1:0] en, input logic [1:0] key, input int b0,
                               input int b1, input logic [14:0] bg, input int fade);
    idle(4);
    set_cfg(en, key, b0, b1, bg, fade);
    cfg_stb = 1; tick(); cfg_stb = 0;
    frame_start = 1; tick(); frame_start = 0;
  endtask

  task automatic rand_pixel();
    dx = 16'($urandom); dy = 16'($urandom);
    hsync = 1'($urandom); vsync = 1'($urandom); de = 1'($urandom);
    layer_paint = 2'($urandom); layer_pix = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 15'($urandom);
    mem[200] = 15'h7FFF;

    // Reset state
    repeat (2) @(posedge clk_pix);
    #1;
    chk("reset_disp", 64'(obs()), 64'(0));
    chk("reset_clut_addr", 64'(dif.clut_addr), 64'(0));
    chk("reset_pending", 64'(cfg_pending), 64'(0));
    rst_pix = 0;
    model_reset();

    // Background at defaults
    de = 1; dx = 16'd10; dy = 16'd3;
    repeat (5) tick();
    chk("bg_default", 64'({dif.disp_r, dif.disp_g, dif.disp_b}), 64'({5'd2, 5'd4, 5'd6}));

    // Transparency key
    de = 1; layer_paint = 2'b11; layer_pix = {4'd7, 4'd0};
    tick();
    chk("key_skip", 64'(dif.clut_addr), 64'(7));
    program_frame(2'b11, 2'b10, 0, 0, 15'h0886, 16);
    de = 1; layer_paint = 2'b11; layer_pix = {4'd7, 4'd0};
    tick();
    chk("key_off", 64'(dif.clut_addr), 64'(0));

    // Priority and palette base
    program_frame(2'b11, 2'b11, 0, 16, 15'h0886, 16);
    de = 1; layer_paint = 2'b11; layer_pix = {4'd5, 4'd3};
    tick();
    chk("prio_l0", 64'(dif.clut_addr), 64'(3));
    layer_paint = 2'b10;
    tick();
    chk("prio_l1", 64'(dif.clut_addr), 64'(21));
    repeat (6) tick();

    // Mid-frame cfg_stb is held until frame_start
    set_cfg(2'b11, 2'b11, 192, 0, 15'h0886, 8);
    layer_paint = 2'b01; layer_pix = {4'd0, 4'd8};
    cfg_stb = 1; tick(); cfg_stb = 0;
    chk("stb_pending", 64'(cfg_pending), 64'(1));
    repeat (5) tick();
    idle(4);
    frame_start = 1; tick(); frame_start = 0;
    chk("apply_pending", 64'(cfg_pending), 64'(0));
    de = 1; layer_paint = 2'b01; layer_pix = {4'd0, 4'd8};
    repeat (5) tick();
    chk("fade8", 64'({dif.disp_r, dif.disp_g, dif.disp_b}), 64'({5'd15, 5'd15, 5'd15}));

    // Simultaneous cfg_stb and frame_start with nothing pending
    idle(4);
    set_cfg(2'b11, 2'b11, 250, 0, 15'h7C00, 16);
    cfg_stb = 1; frame_start = 1; tick(); cfg_stb = 0; frame_start = 0;
    chk("same_cycle_pending", 64'(cfg_pending), 64'(1));
    de = 1; layer_paint = 2'b01; layer_pix = {4'd0, 4'd10};
    tick();
    chk("same_cycle_not_applied", 64'(dif.clut_addr), 64'(202));
    idle(4);
    frame_start = 1; tick(); frame_start = 0;
    de = 1; layer_paint = 2'b01; layer_pix = {4'd0, 4'd10};
    tick();
    chk("pal_wrap", 64'(dif.clut_addr), 64'(4));
    repeat (5) tick();

    // Reset mid-line
    de = 1; layer_paint = 2'b11; layer_pix = 8'h35;
    @(posedge clk_pix); #3;
    rst_pix = 1; #1;
    chk("midreset_disp", 64'(obs()), 64'(0));
    chk("midreset_clut_addr", 64'(dif.clut_addr), 64'(0));
    @(posedge clk_pix); #1;
    rst_pix = 0;
    model_reset();
    repeat (8) tick();

    // Randomized frames with random timing, painting and configuration
    for (int fr = 0; fr < 12; fr++) begin
      idle(4);
      frame_start = 1;
      cfg_stb = 1'($urandom_range(0, 2) == 0);
      set_cfg(2'($urandom), 2'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
              15'($urandom), $urandom_range(0, 20));
      tick();
      frame_start = 0; cfg_stb = 0;
      for (int k = 0; k < 40; k++) begin
        rand_pixel();
        cfg_stb = 1'($urandom_range(0, 7) == 0);
        if (cfg_stb)
          set_cfg(2'($urandom), 2'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
                  15'($urandom), $urandom_range(0, 20));
        tick();
      end
      cfg_stb = 0;
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
